wb_arbiter_rr: RTL and testbench
================================

Name: wb_arbiter_rr

Overview:
- Registered round-robin bus arbiter for the shared Wishbone interconnect.
- Decides which of MASTERS_NUM masters owns the shared master->slave bus.
- Holds ownership for the whole cycle (cyc high), with one idle turnaround cycle between owners.
- Runs an optional bus watchdog that ends stalled transfers with an err to the owning master; the interconnect mux consumes gnt_idx_o.

Parameters:
MASTERS_NUM, 2, number of requesting masters (2..16)
TIMEOUT_CYCLES, 255, stalled-stb cycles before the watchdog fires (1..65535)
IDX_W, $clog2(MASTERS_NUM) (min 1), localparam, width of grant index

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low
m_cyc_i  in  MASTERS_NUM  per-master cyc (bus request)
m_stb_i  in  MASTERS_NUM  per-master stb
s_ack_i  in  1  ack from the currently selected slave (already muxed)
s_err_i  in  1  err from the currently selected slave (already muxed)
gnt_o  out  MASTERS_NUM  one-hot grant
gnt_idx_o  out  IDX_W  binary index of granted master
gnt_valid_o  out  1  a master currently owns the bus
bus_abort_o  out  1  force slave-side cyc/stb low (watchdog abort)
m_tmo_err_o  out  MASTERS_NUM  one-cycle err pulse to the timed-out master

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, bus_abort_o=0, m_tmo_err_o=0, last=MASTERS_NUM-1 (so master 0 wins first), watchdog count=0.
- All outputs come from registers; no combinational path from input to output.
- States: IDLE, OWN, ABORT.
- IDLE:
  - If |m_cyc_i: pick the first requester scanning last+1, last+2, ... modulo MASTERS_NUM.
  - Next cycle: gnt_o/gnt_idx_o hold the winner, gnt_valid_o=1, last<=winner, go to OWN.
  - Grant latency is 1 cycle from cyc seen.
  - With no requests, stay in IDLE with outputs cleared.
- OWN:
  - While m_cyc_i[gnt_idx_o]=1: hold the grant; other requests are ignored.
  - When m_cyc_i[gnt_idx_o]=0: next cycle gnt_o=0, gnt_valid_o=0, go to IDLE.
  - This gives a mandatory 1-cycle gap; back-to-back grants to different masters are never contiguous.
- Watchdog, active only in OWN:
  - cnt increments each cycle with m_stb_i[gnt]=1 and s_ack_i=0 and s_err_i=0.
  - cnt clears on ack, on err, or when stb is low.
  - cnt saturates and does not wrap; width is $clog2(TIMEOUT_CYCLES+1).
  - When cnt==TIMEOUT_CYCLES-1 and still stalled: next cycle m_tmo_err_o[gnt]=1 for exactly 1 cycle, bus_abort_o=1, go to ABORT.
- ABORT:
  - bus_abort_o stays 1 and the grant is held until the owner drops cyc.
  - Then clear everything and go to IDLE (same 1-cycle gap).
  - A late s_ack_i/s_err_i in ABORT is ignored.
- Simultaneous ack and timeout threshold in the same cycle: ack wins, cnt clears, no err.
- Owner drops cyc in the same cycle the threshold is reached: release wins, no err pulse.
- Requests from non-owners are never lost: masters hold cyc until granted; the arbiter keeps no request memory.
- Asynchronous reset mid-OWN/ABORT: immediate return to reset values; priority pointer restarts at master 0.
- Single requester repeatedly: it is re-granted after each 1-cycle gap.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined: watchdog, ABORT state, bus_abort_o and m_tmo_err_o behave as above.
- Undefined: no counter or ABORT state; bus_abort_o and m_tmo_err_o are tied to 0; TIMEOUT_CYCLES is unused. Ports remain, so the interface is unchanged.

Test Plan:
- Reset then m_cyc_i=2'b11 held -> next cycle gnt_o=2'b01, gnt_idx_o=0. Master 0 drops cyc -> 1 idle cycle (gnt_valid_o=0), then gnt_o=2'b10.
- MASTERS_NUM=4, all request, each holds cyc 3 cycles -> grant order 0,1,2,3,0 with a gnt_valid_o=0 gap between each.
- Only master 1 requests, 5 cycles, repeated 3 times -> granted each time, gnt_idx_o=1, last pointer does not starve it.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, master 0 stb=1 with no ack -> m_tmo_err_o=2'b01 for exactly 1 cycle on the 5th cycle after stb, bus_abort_o=1 until cyc drops.
- Same setup but s_ack_i=1 on cycle 4 (threshold cycle) -> no err; cnt restarts, transfer completes normally.
- rst_n_i pulsed low mid-OWN with master 1 granted -> gnt_o=0 immediately (async); after release with both requesting -> master 0 granted first.

Source files
------------

// File: rtl/wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// wb_arbiter_rr : registered round-robin arbiter for the shared Wishbone bus.
//
// A master keeps the bus for as long as it holds cyc. After each release
// there is one idle turnaround cycle, and then the next requester is chosen
// by scanning upward from the previous owner. Every output is a register.
//
// Optional feature, macro WB_ARB_TIMEOUT_EN:
//   defined   - bus watchdog. When the owner's stb stays stalled for
//               TIMEOUT_CYCLES cycles, the owner gets a one-cycle err on
//               m_tmo_err_o, and bus_abort_o stays high until the owner drops
//               cyc.
//   undefined - there is no watchdog. bus_abort_o and m_tmo_err_o are tied
//               low, and TIMEOUT_CYCLES is ignored.
//
// Ports:
//   clk_i, rst_n_i   clock; asynchronous active-low reset
//   m_cyc_i/m_stb_i  per-master cyc (bus request) / stb
//   s_ack_i/s_err_i  ack / err from the selected slave (already muxed)
//   gnt_o            one-hot grant
//   gnt_idx_o        binary index of the granted master (drives the mux)
//   gnt_valid_o      a master currently owns the bus
//   bus_abort_o      force slave-side cyc/stb low after a watchdog abort
//   m_tmo_err_o      one-cycle err pulse to the timed-out master
// ---------------------------------------------------------------------------
module wb_arbiter_rr #(
    parameter  int MASTERS_NUM    = 2,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int IDX_W          = (MASTERS_NUM > 1) ? $clog2(MASTERS_NUM) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [MASTERS_NUM-1:0] m_cyc_i,
    input  logic [MASTERS_NUM-1:0] m_stb_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    output logic [MASTERS_NUM-1:0] gnt_o,
    output logic [IDX_W-1:0]       gnt_idx_o,
    output logic                   gnt_valid_o,
    output logic                   bus_abort_o,
    output logic [MASTERS_NUM-1:0] m_tmo_err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN   = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [1:0] ST_ABORT = 2'd2;
    localparam int         CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
`endif
    localparam logic [MASTERS_NUM-1:0] ONE = MASTERS_NUM'(1);

    logic [1:0]             r_state;
    logic [MASTERS_NUM-1:0] r_gnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_valid;
    logic [IDX_W-1:0]       r_last;

    logic [IDX_W-1:0]       w_win;
    logic [IDX_W-1:0]       w_cand;
    logic                   w_found;
    logic                   w_own_cyc;

    assign w_own_cyc = m_cyc_i[r_idx];

    // Scan last+1, last+2, ... modulo MASTERS_NUM. The previous owner is
    // checked last, so it can win only when nobody else is asking.
    always_comb begin
        w_win   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= MASTERS_NUM; i++) begin
            w_cand = IDX_W'((int'(r_last) + i) % MASTERS_NUM);
            if (!w_found && m_cyc_i[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic                   r_abort;
    logic [MASTERS_NUM-1:0] r_tmo_err;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_stall;

    // A stall is a cycle in which the owner strobes and the slave neither
    // acks nor errs. An ack therefore beats the threshold in the same cycle.
    assign w_stall = m_stb_i[r_idx] & ~s_ack_i & ~s_err_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_last    <= IDX_W'(MASTERS_NUM - 1);
`ifdef WB_ARB_TIMEOUT_EN
            r_abort   <= 1'b0;
            r_tmo_err <= '0;
            r_cnt     <= '0;
`endif
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            r_tmo_err <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_OWN;
                        r_gnt   <= ONE << w_win;
                        r_idx   <= w_win;
                        r_valid <= 1'b1;
                        r_last  <= w_win;
                    end
                end
                ST_OWN: begin
                    // If the owner releases in the same cycle the threshold
                    // is reached, the release wins.
                    if (!w_own_cyc) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (w_stall && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= ST_ABORT;
                        r_abort   <= 1'b1;
                        r_tmo_err <= r_gnt;
                        r_cnt     <= '0;
                    end else if (w_stall) begin
                        if (r_cnt != '1)
                            r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
`endif
                    end
                end
`ifdef WB_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    // A late ack or err is ignored here. Only the owner
                    // dropping cyc ends the abort.
                    if (!w_own_cyc) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_abort <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_idx;
    assign gnt_valid_o = r_valid;

`ifdef WB_ARB_TIMEOUT_EN
    assign bus_abort_o = r_abort;
    assign m_tmo_err_o = r_tmo_err;
`else
    // Without the watchdog these inputs do not affect anything.
    logic w_unused;
    assign w_unused    = ^{m_stb_i, s_ack_i, s_err_i, (TIMEOUT_CYCLES > 0)};
    assign bus_abort_o = 1'b0;
    assign m_tmo_err_o = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_rr : directed bench for wb_arbiter_rr.
// u_dut2 : MASTERS_NUM=2, TIMEOUT_CYCLES=4  (pairing, watchdog, reset)
// u_dut4 : MASTERS_NUM=4                    (round-robin order, single requester)
// ---------------------------------------------------------------------------
module tb_wb_arbiter_rr;

`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [1:0] cyc2 = '0, stb2 = '0, gnt2, tmo2;
    logic [0:0] idx2;
    logic       ack2 = 1'b0, err2 = 1'b0, vld2, abt2;

    logic [3:0] cyc4 = '0, stb4 = '0, gnt4, tmo4;
    logic [1:0] idx4;
    logic       vld4, abt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arbiter_rr #(.MASTERS_NUM(2), .TIMEOUT_CYCLES(4)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_cyc_i(cyc2), .m_stb_i(stb2), .s_ack_i(ack2), .s_err_i(err2),
        .gnt_o(gnt2), .gnt_idx_o(idx2), .gnt_valid_o(vld2),
        .bus_abort_o(abt2), .m_tmo_err_o(tmo2)
    );

    wb_arbiter_rr #(.MASTERS_NUM(4), .TIMEOUT_CYCLES(255)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_cyc_i(cyc4), .m_stb_i(stb4), .s_ack_i(1'b0), .s_err_i(1'b0),
        .gnt_o(gnt4), .gnt_idx_o(idx4), .gnt_valid_o(vld4),
        .bus_abort_o(abt4), .m_tmo_err_o(tmo4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset values
        #2;
        chk("rst_gnt2", 32'(gnt2), 0);
        chk("rst_idx2", 32'(idx2), 0);
        chk("rst_vld2", 32'(vld2), 0);
        chk("rst_abt2", 32'(abt2), 0);
        chk("rst_tmo2", 32'(tmo2), 0);
        chk("rst_gnt4", 32'(gnt4), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_vld2", 32'(vld2), 0);

        // ---- two masters: 0 wins first, 1 after a one-cycle gap
        cyc2 = 2'b11;
        tick();
        chk("p1_gnt", 32'(gnt2), 32'h1);
        chk("p1_idx", 32'(idx2), 0);
        chk("p1_vld", 32'(vld2), 1);
        tick();
        chk("p1_hold", 32'(gnt2), 32'h1);
        cyc2 = 2'b10;
        tick();
        chk("p1_gap_vld", 32'(vld2), 0);
        chk("p1_gap_gnt", 32'(gnt2), 0);
        tick();
        chk("p1_gnt_m1", 32'(gnt2), 32'h2);
        chk("p1_idx_m1", 32'(idx2), 1);
        cyc2 = 2'b00;
        tick();
        chk("p1_rel", 32'(vld2), 0);

        // ---- four masters all requesting: order 0,1,2,3,0 with a gap between
        cyc4 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt4), 32'(1 << (k % 4)));
            chk("rr_idx", 32'(idx4), 32'(k % 4));
            tick(); tick();
            chk("rr_hold", 32'(gnt4), 32'(1 << (k % 4)));
            cyc4[k % 4] = 1'b0;
            tick();
            chk("rr_gap", 32'(vld4), 0);
            cyc4[k % 4] = 1'b1;
        end
        cyc4 = 4'b0000;
        tick();
        chk("rr_idle", 32'(vld4), 0);

        // ---- single requester (master 1) re-granted three times
        for (int r = 0; r < 3; r++) begin
            cyc4 = 4'b0010;
            tick();
            chk("solo_idx", 32'(idx4), 1);
            chk("solo_vld", 32'(vld4), 1);
            repeat (4) tick();
            cyc4 = 4'b0000;
            tick();
            chk("solo_gap", 32'(vld4), 0);
        end

        // ---- watchdog fires on the 5th owned cycle with stb stalled
        cyc2 = 2'b01; stb2 = 2'b01;
        tick();
        chk("wd_gnt", 32'(gnt2), 32'h1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("wd_pre_tmo", 32'(tmo2), 0);
            chk("wd_pre_abt", 32'(abt2), 0);
        end
        tick();
        chk("wd_tmo", 32'(tmo2), TMO ? 32'h1 : 32'h0);
        chk("wd_abt", 32'(abt2), 32'(TMO));
        ack2 = 1'b1;
        tick();
        chk("wd_tmo_1cyc", 32'(tmo2), 0);
        chk("wd_abt_hold", 32'(abt2), 32'(TMO));
        chk("wd_gnt_hold", 32'(gnt2), 32'h1);
        ack2 = 1'b0;
        cyc2 = 2'b00; stb2 = 2'b00;
        tick();
        chk("wd_rel_abt", 32'(abt2), 0);
        chk("wd_rel_vld", 32'(vld2), 0);

        // ---- ack on the threshold cycle: no err, and the count restarts
        cyc2 = 2'b01; stb2 = 2'b01;
        tick();
        chk("ack_gnt", 32'(gnt2), 32'h1);
        repeat (3) tick();
        ack2 = 1'b1;
        tick();
        chk("ack_no_tmo", 32'(tmo2), 0);
        chk("ack_no_abt", 32'(abt2), 0);
        ack2 = 1'b0;
        repeat (3) tick();
        chk("ack_restart", 32'(tmo2), 0);
        chk("ack_still_own", 32'(vld2), 1);
        cyc2 = 2'b00; stb2 = 2'b00;
        tick();
        chk("ack_done", 32'(vld2), 0);
        chk("ack_done_tmo", 32'(tmo2), 0);

        // ---- owner releases on the threshold cycle: release wins
        cyc2 = 2'b01; stb2 = 2'b01;
        repeat (4) tick();
        cyc2 = 2'b00;
        tick();
        chk("relwin_tmo", 32'(tmo2), 0);
        chk("relwin_abt", 32'(abt2), 0);
        chk("relwin_vld", 32'(vld2), 0);
        stb2 = 2'b00;
        tick();

        // ---- asynchronous reset mid-OWN with master 1 granted
        cyc2 = 2'b10;
        tick();
        chk("ar_idx", 32'(idx2), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt2), 0);
        chk("ar_vld", 32'(vld2), 0);
        cyc2 = 2'b11;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_first_m0", 32'(gnt2), 32'h1);
        chk("ar_idx_m0", 32'(idx2), 0);
        cyc2 = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
